// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : LEGv8 instruction-fetch stage. Holds the PC, addresses the
//               instruction ROM and captures the fetched word into IF/ID.
//               Optional perf counters are enabled by FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  IMEM_DEPTH = 20,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]         NOP_INSTR  = 32'hd503201f
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_q,
  output logic [PC_WIDTH-1:0]   ifid_pc,
  output logic [31:0]           ifid_instr,
  output logic                  ifid_valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count
);

  localparam logic [PC_WIDTH-1:0]   c_pc_step    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0]   c_align_mask = PC_WIDTH'(3);
  localparam logic [ADDR_WIDTH:0]   c_depth      = (ADDR_WIDTH+1)'(IMEM_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_ifid_pc;
  logic [31:0]         r_ifid_instr;
  logic                r_ifid_valid;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_upper_zero;
  logic                  w_in_range;
  logic [PC_WIDTH-1:0]   w_target;

  assign w_addr       = r_pc[ADDR_WIDTH+1:2];
  // The word index alone aliases above the ROM window, so the upper PC bits must be zero too.
  assign w_upper_zero = (r_pc[PC_WIDTH-1:ADDR_WIDTH+2] == '0);
  assign w_in_range   = w_upper_zero && ({1'b0, w_addr} < c_depth);
  assign w_target     = branch_target & ~c_align_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      r_pc         <= w_target;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_pc      <= r_pc + c_pc_step;
      r_ifid_pc <= r_pc;
      if (w_in_range) begin
        r_ifid_instr <= imem_q;
        r_ifid_valid <= 1'b1;
      end else begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else if (branch_taken) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end else if (!stall) begin
      if (w_in_range) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`else
  assign fetch_count  = '0;
  assign bubble_count = '0;
`endif

  assign imem_addr  = w_addr;
  assign pc         = r_pc;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage; directed vectors with
//               hand-computed expectations. Honours FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_nop = 32'hd503201f;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [63:0] pc;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic [5:0]  addr;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_q       (imem_q),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .pc           (pc),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );

  assign imem_q = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = (i < 20) ? (32'h1000_0000 + 32'(i)) : (32'hBAD0_0000 + 32'(i));
    end
    rom[0] = 32'h8b1f03e0;
    rom[5] = 32'h91002001;
  end

  function automatic logic [31:0] cnt(input logic [31:0] x);
`ifdef FETCH_PERF_CNT_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents a new IF/ID state every cycle; compare whenever one is expected.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.name, "pc",           pc,                   e.pc);
      cmp(e.name, "ifid_pc",      ifid_pc,              e.ipc);
      cmp(e.name, "ifid_instr",   64'(ifid_instr),      64'(e.instr));
      cmp(e.name, "ifid_valid",   64'(ifid_valid),      64'(e.v));
      cmp(e.name, "imem_addr",    64'(imem_addr),       64'(e.addr));
      cmp(e.name, "fetch_count",  64'(fetch_count),     64'(e.fc));
      cmp(e.name, "bubble_count", 64'(bubble_count),    64'(e.bc));
    end
  end

  task automatic tick(input logic rn, input logic s, input logic b, input logic [63:0] t);
    @(negedge clk);
    reset         = rn;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  task automatic expect_state(input string nm, input logic [63:0] epc, input logic [63:0] eipc,
                              input logic [31:0] ei, input logic ev, input logic [5:0] ea,
                              input logic [31:0] efc, input logic [31:0] ebc);
    exp_t x;
    x.name = nm; x.pc = epc; x.ipc = eipc; x.instr = ei; x.v = ev; x.addr = ea;
    x.fc = cnt(efc); x.bc = cnt(ebc);
    sb.push_back(x);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset then free run
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    expect_state("reset", 64'h0, 64'h0, c_nop, 1'b0, 6'd0, 0, 0);
    adv(1);
    expect_state("cyc1", 64'h4, 64'h0, 32'h8b1f03e0, 1'b1, 6'd1, 1, 0);
    adv(4);
    adv(1);
    expect_state("cyc6", 64'h18, 64'h14, 32'h91002001, 1'b1, 6'd6, 6, 0);

    // Stall at pc 0x08
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    expect_state("reset2", 64'h0, 64'h0, c_nop, 1'b0, 6'd0, 0, 0);
    adv(2);
    expect_state("pre_stall", 64'h8, 64'h4, 32'h1000_0001, 1'b1, 6'd2, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 64'h0);
      expect_state("stall", 64'h8, 64'h4, 32'h1000_0001, 1'b1, 6'd2, 2, 0);
    end
    adv(1);
    expect_state("unstall", 64'hC, 64'h8, 32'h1000_0002, 1'b1, 6'd3, 3, 0);

    // Redirect with simultaneous stall, unaligned target
    tick(1'b1, 1'b1, 1'b1, 64'h3F);
    expect_state("redirect", 64'h3C, 64'h0, c_nop, 1'b0, 6'hF, 3, 1);
    adv(1);
    expect_state("post_redir", 64'h40, 64'h3C, 32'h1000_000F, 1'b1, 6'h10, 4, 1);
    adv(4);
    adv(1);
    expect_state("idx20", 64'h54, 64'h50, c_nop, 1'b0, 6'h15, 8, 2);

    // ROM-window edge and address aliasing
    tick(1'b1, 1'b0, 1'b1, 64'hF8);
    expect_state("redir_f8", 64'hF8, 64'h0, c_nop, 1'b0, 6'h3E, 8, 3);
    adv(1);
    expect_state("pc_fc", 64'hFC, 64'hF8, c_nop, 1'b0, 6'h3F, 8, 4);
    adv(1);
    expect_state("pc_100", 64'h100, 64'hFC, c_nop, 1'b0, 6'h0, 8, 5);
    adv(1);
    expect_state("alias_100", 64'h104, 64'h100, c_nop, 1'b0, 6'h1, 8, 6);

    // PC wrap at 2^64
    tick(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_state("redir_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, c_nop, 1'b0, 6'h3F, 8, 7);
    adv(1);
    expect_state("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, c_nop, 1'b0, 6'h0, 8, 8);
    adv(1);
    expect_state("after_wrap", 64'h4, 64'h0, 32'h8b1f03e0, 1'b1, 6'h1, 9, 8);

    // Reset mid-run at pc 0x30, with stall and redirect asserted
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    expect_state("reset3", 64'h0, 64'h0, c_nop, 1'b0, 6'd0, 0, 0);
    adv(12);
    expect_state("pc_30", 64'h30, 64'h2C, 32'h1000_000B, 1'b1, 6'hC, 12, 0);
    tick(1'b0, 1'b1, 1'b1, 64'h40);
    expect_state("reset_mid", 64'h0, 64'h0, c_nop, 1'b0, 6'd0, 0, 0);

    // 10 advances, 2 stalls, 1 redirect
    adv(5);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    expect_state("cnt_stall", 64'h14, 64'h10, 32'h1000_0004, 1'b1, 6'd5, 5, 0);
    adv(5);
    tick(1'b1, 1'b0, 1'b1, 64'h8);
    expect_state("cnt_final", 64'h8, 64'h0, c_nop, 1'b0, 6'd2, 10, 1);

    tick(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline: holds the PC, drives the word address into the 64-entry x 32-bit instruction ROM and captures the returned word into the IF/ID pipeline register.
- Sits directly upstream of the instruction ROM and decode: supplies the ROM address, consumes the ROM's combinational output and feeds decode.
- Handles pipeline stall, branch redirect/flush and out-of-range fetch.

Parameters:
- PC_WIDTH, 64, width of PC and branch target.
- ADDR_WIDTH, 6, ROM word-address width.
- IMEM_DEPTH, 20, populated ROM words; indices >= IMEM_DEPTH are out of range.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hd503201f, bubble instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low (asserted when 0).
- stall  in  1  hold PC and IF/ID.
- branch_taken  in  1  redirect fetch; flush IF/ID.
- branch_target  in  PC_WIDTH  redirect address.
- imem_addr  out  ADDR_WIDTH  ROM word address.
- imem_q  in  32  ROM data (combinational from imem_addr).
- ifid_pc  out  PC_WIDTH  PC of the instruction held in IF/ID.
- ifid_instr  out  32  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction.
- pc  out  PC_WIDTH  current fetch PC.
- fetch_count  out  32  fetched-instruction counter (optional feature).
- bubble_count  out  32  bubble counter (optional feature).

Behaviour:
- imem_addr = pc[ADDR_WIDTH+1:2], combinational; no extra latency. The instruction at PC appears in IF/ID one cycle after PC presents it.
- in_range = (pc[PC_WIDTH-1:ADDR_WIDTH+2] == 0) && (imem_addr < IMEM_DEPTH).
- Per-posedge priority is reset > branch_taken > stall > advance.
- Reset (reset==0): pc<=RESET_PC, ifid_pc<=0, ifid_instr<=NOP_INSTR, ifid_valid<=0, both counters <=0. Reset mid-stall or mid-redirect wins unconditionally.
- branch_taken==1: pc<={branch_target[PC_WIDTH-1:2],2'b00} (low bits forced to 0); IF/ID flushed to ifid_pc<=0, ifid_instr<=NOP_INSTR, ifid_valid<=0. Redirect overrides a simultaneous stall.
- stall==1 (no redirect): pc, ifid_pc, ifid_instr and ifid_valid all hold.
- Advance, in range: pc<=pc+4, ifid_pc<=pc, ifid_instr<=imem_q, ifid_valid<=1.
- Advance, out of range: pc<=pc+4, ifid_pc<=pc, ifid_instr<=NOP_INSTR, ifid_valid<=0. imem_q is ignored.
- pc+4 wraps modulo 2^PC_WIDTH. imem_addr wraps naturally (pc 0xFC -> 0x100 gives addr 0), but the upper-bit check makes 0x100 out of range.
- Outputs are registered only, except imem_addr. No combinational path from stall or branch_taken to any output.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - fetch_count increments on each advance cycle that loads ifid_valid=1.
  - bubble_count increments on each redirect-flush cycle and each out-of-range advance cycle.
  - Stall cycles increment neither counter.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: no counter registers; fetch_count and bubble_count are tied to 0.

Test Plan:
- Reset then free-run, bench ROM word0=32'h8b1f03e0, word5=32'h91002001 -> at cycle 1 ifid_instr=8b1f03e0, ifid_pc=0, ifid_valid=1; at cycle 6 ifid_instr=91002001, ifid_pc=0x14, pc=0x18.
- stall=1 for 3 cycles at pc=0x08 -> pc stays 0x08 and IF/ID holds word1 for 3 cycles; releasing the stall resumes with word2.
- branch_taken=1, branch_target=0x3F with stall=1 in the same cycle -> pc=0x3C, ifid_valid=0, ifid_instr=d503201f; the next cycle ifid_pc=0x3C.
- Run to pc=0x50 (index 20) -> ifid_instr=d503201f, ifid_valid=0, pc=0x54. Run to pc=0xFC then 0x100 -> imem_addr=0, ifid_valid=0.
- reset=0 asserted mid-run at pc=0x30 -> next cycle pc=0, ifid_valid=0, ifid_instr=d503201f, counters=0.
- With FETCH_PERF_CNT_EN: 10 advances, 1 redirect, 2 stalls -> fetch_count=10, bubble_count=1. Without the macro, both read 0.
